// File: rtl/ddr3_mch_rw_arb_if.sv
// Burst handshake between the DDR3 request arbiter and the AXI master.
// master: arbiter side (drives requests), slave: AXI master side (drives finishes).
interface ddr3_mch_rw_arb_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LEN_W  = 10,
  parameter int unsigned CH_W   = 1
);
  logic              wd_req;
  logic [ADDR_W-1:0] wd_addr;
  logic [LEN_W-1:0]  wd_len;
  logic [CH_W-1:0]   wd_ch;
  logic              wd_finish;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic [CH_W-1:0]   rd_ch;
  logic              rd_finish;
  logic              busy;

  modport master (
    output wd_req, wd_addr, wd_len, wd_ch,
    output rd_req, rd_addr, rd_len, rd_ch,
    output busy,
    input  wd_finish, rd_finish
  );

  modport slave (
    input  wd_req, wd_addr, wd_len, wd_ch,
    input  rd_req, rd_addr, rd_len, rd_ch,
    input  busy,
    output wd_finish, rd_finish
  );
endinterface

// File: rtl/ddr3_mch_rw_arb.sv
// Multi-channel DDR3 read/write burst arbiter and address generator (ui_clk domain).
// Requesters 0..CH_NUM-1 are write channels, CH_NUM..2*CH_NUM-1 are read channels.
// Optional ping-pong banking is enabled by defining DDR3_PINGPONG_EN.
module ddr3_mch_rw_arb #(
  parameter int unsigned       CH_NUM      = 2,
  parameter int unsigned       ADDR_W      = 28,
  parameter int unsigned       LEN_W       = 10,
  parameter int unsigned       CNT_W       = 11,
  parameter int unsigned       RFIFO_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BANK_OFFS   = ADDR_W'(28'h0800000)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_ddr3_init_done,
  input  logic [CH_NUM-1:0]        i_wr_load,
  input  logic [CH_NUM-1:0]        i_rd_load,
  input  logic [CH_NUM-1:0]        i_rd_valid,
  input  logic [CH_NUM*ADDR_W-1:0] i_addr_wd_min,
  input  logic [CH_NUM*ADDR_W-1:0] i_addr_wd_max,
  input  logic [CH_NUM*ADDR_W-1:0] i_addr_rd_min,
  input  logic [CH_NUM*ADDR_W-1:0] i_addr_rd_max,
  input  logic [CH_NUM*LEN_W-1:0]  i_wd_burst_len,
  input  logic [CH_NUM*LEN_W-1:0]  i_rd_burst_len,
  input  logic [CH_NUM*CNT_W-1:0]  i_wfifo_rcount,
  input  logic [CH_NUM*CNT_W-1:0]  i_rfifo_wcount,
  ddr3_mch_rw_arb_if.master        bus
);
  localparam int unsigned NREQ  = 2 * CH_NUM;
  localparam int unsigned RR_W  = $clog2(NREQ);
  localparam int unsigned CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned CMP_W = ((CNT_W > LEN_W) ? CNT_W : LEN_W) + 1;
  localparam logic [RR_W-1:0] CH_NUM_R = RR_W'(CH_NUM);
  localparam logic [RR_W-1:0] LAST_R   = RR_W'(NREQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_UPDATE} state_t;

  state_t            r_state;
  logic [RR_W-1:0]   r_rr;
  logic [RR_W-1:0]   r_win;
  logic              r_is_rd;
  logic              r_ld_pend;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_ptr [NREQ];

  logic [ADDR_W-1:0] w_min [NREQ];
  logic [ADDR_W-1:0] w_max [NREQ];
  logic [LEN_W-1:0]  w_len [NREQ];
  logic [ADDR_W-1:0] w_eff [NREQ];
  logic [NREQ-1:0]   w_elig;
  logic [NREQ-1:0]   w_load;
  logic              w_found;
  logic [RR_W-1:0]   w_win;
  logic [CH_W-1:0]   w_win_ch;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [ADDR_W:0]   w_next;
  logic [ADDR_W+1:0] w_end;
  logic              w_wrap;
  logic              w_to_min;
  logic [ADDR_W-1:0] w_upd_ptr;

  assign w_load = {i_rd_load, i_wr_load};

  // Per-channel unpacking, eligibility and effective (load/clamp-adjusted) pointer.
  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    assign w_min[g]        = i_addr_wd_min[g*ADDR_W +: ADDR_W];
    assign w_max[g]        = i_addr_wd_max[g*ADDR_W +: ADDR_W];
    assign w_len[g]        = i_wd_burst_len[g*LEN_W +: LEN_W];
    assign w_min[g+CH_NUM] = i_addr_rd_min[g*ADDR_W +: ADDR_W];
    assign w_max[g+CH_NUM] = i_addr_rd_max[g*ADDR_W +: ADDR_W];
    assign w_len[g+CH_NUM] = i_rd_burst_len[g*LEN_W +: LEN_W];

    assign w_elig[g] = i_ddr3_init_done && (w_len[g] != '0) && (w_min[g] < w_max[g]) &&
                       (CMP_W'(i_wfifo_rcount[g*CNT_W +: CNT_W]) >= CMP_W'(w_len[g]));
    assign w_elig[g+CH_NUM] = i_ddr3_init_done && i_rd_valid[g] && (w_len[g+CH_NUM] != '0) &&
                       (w_min[g+CH_NUM] < w_max[g+CH_NUM]) &&
                       ((CMP_W'(i_rfifo_wcount[g*CNT_W +: CNT_W]) + CMP_W'(w_len[g+CH_NUM]))
                        <= CMP_W'(RFIFO_DEPTH));
  end

  for (genvar k = 0; k < NREQ; k++) begin : g_eff
    assign w_eff[k] = (w_load[k] || (r_ptr[k] < w_min[k])) ? w_min[k] : r_ptr[k];
  end

  // Round-robin pick: first eligible requester scanning upward from r_rr.
  always_comb begin
    int unsigned v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      v_idx = 32'(r_rr) + j;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
      if (!w_found && w_elig[RR_W'(v_idx)]) begin
        w_found = 1'b1;
        w_win   = RR_W'(v_idx);
      end
    end
  end

  assign w_win_ch = CH_W'((w_win >= CH_NUM_R) ? (w_win - CH_NUM_R) : w_win);

  // Pointer advance for the granted burst; a pending or coincident load wins over it.
  assign w_next    = (ADDR_W+1)'(r_base) + (ADDR_W+1)'(r_len);
  assign w_end     = (ADDR_W+2)'(w_next) + (ADDR_W+2)'(r_len);
  assign w_wrap    = w_end > (ADDR_W+2)'(w_max[r_win]);
  assign w_to_min  = r_ld_pend || w_load[r_win];
  assign w_upd_ptr = (w_to_min || w_wrap) ? w_min[r_win] : ADDR_W'(w_next);

`ifdef DDR3_PINGPONG_EN
  logic [CH_NUM-1:0] r_wbank;
  logic [CH_NUM-1:0] r_rbank;
  logic              w_gnt_bank;
  logic [CH_W-1:0]   w_upd_ch;

  assign w_gnt_bank = (w_win >= CH_NUM_R) ? r_rbank[w_win_ch] : r_wbank[w_win_ch];
  assign w_gnt_addr = w_eff[w_win] + (w_gnt_bank ? BANK_OFFS : '0);
  assign w_upd_ch   = CH_W'(r_is_rd ? (r_win - CH_NUM_R) : r_win);

  // Bank flip on a wrap: writes toggle, reads move to the bank not being written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wbank <= '0;
      r_rbank <= '0;
    end else if (r_state == S_UPDATE && w_wrap && !w_to_min) begin
      if (r_is_rd) r_rbank[w_upd_ch] <= ~r_wbank[w_upd_ch];
      else         r_wbank[w_upd_ch] <= ~r_wbank[w_upd_ch];
    end
  end
`else
  // Offset has no effect without banking.
  logic w_unused_offs;
  assign w_unused_offs = ^BANK_OFFS;
  assign w_gnt_addr    = w_eff[w_win];
`endif

  // Grant FSM with registered request/address outputs and per-requester pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr        <= '0;
      r_win       <= '0;
      r_is_rd     <= 1'b0;
      r_ld_pend   <= 1'b0;
      r_base      <= '0;
      r_len       <= '0;
      for (int unsigned k = 0; k < NREQ; k++) r_ptr[RR_W'(k)] <= '0;
      bus.wd_req  <= 1'b0;
      bus.wd_addr <= '0;
      bus.wd_len  <= '0;
      bus.wd_ch   <= '0;
      bus.rd_req  <= 1'b0;
      bus.rd_addr <= '0;
      bus.rd_len  <= '0;
      bus.rd_ch   <= '0;
      bus.busy    <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (w_load[RR_W'(k)] && !(r_state != S_IDLE && RR_W'(k) == r_win))
          r_ptr[RR_W'(k)] <= w_min[RR_W'(k)];
      end
      case (r_state)
        S_IDLE: begin
          r_ld_pend <= 1'b0;
          if (w_found) begin
            r_state  <= S_GRANT;
            r_win    <= w_win;
            r_is_rd  <= (w_win >= CH_NUM_R);
            r_base   <= w_eff[w_win];
            r_len    <= w_len[w_win];
            bus.busy <= 1'b1;
            if (w_win >= CH_NUM_R) begin
              bus.rd_req  <= 1'b1;
              bus.rd_addr <= w_gnt_addr;
              bus.rd_len  <= w_len[w_win];
              bus.rd_ch   <= w_win_ch;
            end else begin
              bus.wd_req  <= 1'b1;
              bus.wd_addr <= w_gnt_addr;
              bus.wd_len  <= w_len[w_win];
              bus.wd_ch   <= w_win_ch;
            end
          end
        end
        S_GRANT: begin
          bus.wd_req <= 1'b0;
          bus.rd_req <= 1'b0;
          r_state    <= S_WAIT;
          if (w_load[r_win]) r_ld_pend <= 1'b1;
        end
        S_WAIT: begin
          if (w_load[r_win]) r_ld_pend <= 1'b1;
          if (r_is_rd ? bus.rd_finish : bus.wd_finish) r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          r_ptr[r_win] <= w_upd_ptr;
          r_rr         <= (r_win == LAST_R) ? '0 : r_win + 1'b1;
          r_ld_pend    <= 1'b0;
          bus.busy     <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr3_mch_rw_arb.sv
// Directed testbench for ddr3_mch_rw_arb (CH_NUM=2, default build without banking).
module tb_ddr3_mch_rw_arb;
  logic        clk;
  logic        rst;
  logic        init;
  logic [1:0]  wr_load, rd_load, rd_valid;
  logic [55:0] wd_min, wd_max, rd_min, rd_max;
  logic [19:0] wd_len, rd_len;
  logic [21:0] wfifo, rfifo;

  int checks = 0;
  int errors = 0;

  ddr3_mch_rw_arb_if #(.ADDR_W(28), .LEN_W(10), .CH_W(1)) bus ();

  ddr3_mch_rw_arb dut (
    .clk              (clk),
    .rst              (rst),
    .i_ddr3_init_done (init),
    .i_wr_load        (wr_load),
    .i_rd_load        (rd_load),
    .i_rd_valid       (rd_valid),
    .i_addr_wd_min    (wd_min),
    .i_addr_wd_max    (wd_max),
    .i_addr_rd_min    (rd_min),
    .i_addr_rd_max    (rd_max),
    .i_wd_burst_len   (wd_len),
    .i_rd_burst_len   (rd_len),
    .i_wfifo_rcount   (wfifo),
    .i_rfifo_wcount   (rfifo),
    .bus              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {is_rd, is_wr, ch, addr, len} of the request currently on the bus
  function automatic logic [40:0] obs_grant();
    if (bus.rd_req) return {1'b1, 1'b0, bus.rd_ch, bus.rd_addr, bus.rd_len};
    return {1'b0, bus.wd_req, bus.wd_ch, bus.wd_addr, bus.wd_len};
  endfunction

  function automatic logic [40:0] exp_grant(input bit rd, input bit ch, input logic [27:0] a,
                                            input logic [9:0] l);
    return {rd, ~rd, ch, a, l};
  endfunction

  task automatic wait_req(input int budget, output bit got, output int n);
    got = 1'b0;
    n   = 0;
    while (!got && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.wd_req || bus.rd_req) got = 1'b1;
    end
  endtask

  task automatic count_reqs(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.wd_req || bus.rd_req) cnt++;
    end
  endtask

  task automatic pulse_fin(input bit rd);
    @(negedge clk);
    if (rd) bus.rd_finish = 1'b1;
    else    bus.wd_finish = 1'b1;
    @(negedge clk);
    bus.rd_finish = 1'b0;
    bus.wd_finish = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.wd_req, bus.rd_req, bus.busy, bus.wd_ch, bus.rd_ch, bus.wd_addr, bus.rd_addr,
         bus.wd_len, bus.rd_len} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wreq=%b rreq=%b busy=%b waddr=%h raddr=%h exp all zero",
               bus.wd_req, bus.rd_req, bus.busy, bus.wd_addr, bus.rd_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_init;
    bit got; int n; int cnt;
    count_reqs(20, cnt);
    checks++;
    if (cnt !== 0) begin errors++; $display("FAIL init_low_no_req: got %0d reqs exp 0", cnt); end
    init = 1'b1;
    wait_req(6, got, n);
    checks++;
    if (!got || n != 1) begin errors++; $display("FAIL init_latency: got=%b n=%0d exp n=1", got, n); end
    checks++;
    if (obs_grant() !== exp_grant(0, 0, 28'h1000, 10'h40)) begin
      errors++; $display("FAIL init_grant: got %h exp %h", obs_grant(), exp_grant(0, 0, 28'h1000, 10'h40));
    end
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL init_busy: got %b exp 1", bus.busy); end
    pulse_fin(0);
  endtask

  task automatic test_round_robin;
    logic [40:0] exp [4];
    bit got; int n;
    exp[0] = exp_grant(0, 1, 28'h0000, 10'h40);
    exp[1] = exp_grant(1, 0, 28'h2000, 10'h20);
    exp[2] = exp_grant(1, 1, 28'h4000, 10'h10);
    exp[3] = exp_grant(0, 0, 28'h1040, 10'h40);
    for (int i = 0; i < 4; i++) begin
      wait_req(8, got, n);
      checks++;
      if (!got || n != 2) begin errors++; $display("FAIL rr_turnaround[%0d]: got=%b n=%0d exp n=2", i, got, n); end
      checks++;
      if (obs_grant() !== exp[i]) begin
        errors++; $display("FAIL rr_grant[%0d]: got %h exp %h", i, obs_grant(), exp[i]);
      end
      if (i == 1) begin
        pulse_fin(0);
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.rd_req, bus.wd_req} !== 3'b100) begin
          errors++; $display("FAIL rr_wrong_finish_ignored: got busy/rreq/wreq=%b exp 100",
                             {bus.busy, bus.rd_req, bus.wd_req});
        end
      end
      pulse_fin(exp[i][40]);
    end
  endtask

  task automatic test_write_wrap;
    logic [27:0] exp_a [5];
    bit got; int n;
    exp_a[0] = 28'h40; exp_a[1] = 28'h80; exp_a[2] = 28'hC0; exp_a[3] = 28'h00; exp_a[4] = 28'h40;
    wfifo[10:0] = 11'd0;
    rd_valid    = 2'b00;
    for (int i = 0; i < 5; i++) begin
      wait_req(8, got, n);
      checks++;
      if (!got || n != 2 || obs_grant() !== exp_grant(0, 1, exp_a[i], 10'h40)) begin
        errors++; $display("FAIL wrap_addr[%0d]: got %h n=%0d exp %h n=2", i, obs_grant(), n,
                           exp_grant(0, 1, exp_a[i], 10'h40));
      end
      pulse_fin(0);
    end
  endtask

  task automatic test_rd_fifo;
    bit got; int n; int cnt;
    wfifo[21:11] = 11'd0;
    rd_valid     = 2'b01;
    rfifo[10:0]  = 11'd1000;
    count_reqs(10, cnt);
    checks++;
    if (cnt !== 0) begin errors++; $display("FAIL rfifo_1000_blocked: got %0d reqs exp 0", cnt); end
    rfifo[10:0] = 11'd993;
    count_reqs(10, cnt);
    checks++;
    if (cnt !== 0) begin errors++; $display("FAIL rfifo_993_blocked: got %0d reqs exp 0", cnt); end
    rfifo[10:0] = 11'd992;
    wait_req(6, got, n);
    checks++;
    if (!got || n != 1 || obs_grant() !== exp_grant(1, 0, 28'h2020, 10'h20)) begin
      errors++; $display("FAIL rfifo_992_grant: got %h n=%0d exp %h n=1", obs_grant(), n,
                         exp_grant(1, 0, 28'h2020, 10'h20));
    end
    pulse_fin(1);
  endtask

  task automatic test_misconfig;
    int cnt;
    rd_valid = 2'b10;
    rd_max[55:28] = 28'h4000;
    count_reqs(10, cnt);
    checks++;
    if (cnt !== 0) begin errors++; $display("FAIL rd_window_empty: got %0d reqs exp 0", cnt); end
    rd_max[55:28] = 28'h4100;
    rd_len[19:10] = 10'd0;
    count_reqs(10, cnt);
    checks++;
    if (cnt !== 0) begin errors++; $display("FAIL rd_len_zero: got %0d reqs exp 0", cnt); end
    rd_valid      = 2'b00;
    rd_len[19:10] = 10'h10;
    wfifo[10:0]   = 11'h100;
    wd_max[27:0]  = 28'h0800;
    count_reqs(10, cnt);
    checks++;
    if (cnt !== 0) begin errors++; $display("FAIL wd_window_inverted: got %0d reqs exp 0", cnt); end
    wfifo[10:0]  = 11'd0;
    wd_max[27:0] = 28'h1100;
  endtask

  task automatic test_load;
    bit got; int n; int cnt;
    wfifo[10:0] = 11'h100;
    wait_req(6, got, n);
    checks++;
    if (!got || obs_grant() !== exp_grant(0, 0, 28'h1080, 10'h40)) begin
      errors++; $display("FAIL load_pre_grant: got %h exp %h", obs_grant(), exp_grant(0, 0, 28'h1080, 10'h40));
    end
    @(negedge clk);
    wr_load = 2'b11;
    @(negedge clk);
    wr_load = 2'b00;
    checks++;
    if ({bus.busy, bus.wd_addr, bus.wd_len} !== {1'b1, 28'h1080, 10'h40}) begin
      errors++; $display("FAIL load_hold: got busy=%b addr=%h len=%h exp 1 1080 40",
                         bus.busy, bus.wd_addr, bus.wd_len);
    end
    count_reqs(3, cnt);
    checks++;
    if (cnt !== 0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL load_no_abort: got reqs=%0d busy=%b exp 0 1", cnt, bus.busy);
    end
    pulse_fin(0);
    wait_req(8, got, n);
    checks++;
    if (!got || n != 2 || obs_grant() !== exp_grant(0, 0, 28'h1000, 10'h40)) begin
      errors++; $display("FAIL load_restart: got %h n=%0d exp %h", obs_grant(), n, exp_grant(0, 0, 28'h1000, 10'h40));
    end
    pulse_fin(0);
    wait_req(8, got, n);
    checks++;
    if (!got || obs_grant() !== exp_grant(0, 0, 28'h1040, 10'h40)) begin
      errors++; $display("FAIL load_advance: got %h exp %h", obs_grant(), exp_grant(0, 0, 28'h1040, 10'h40));
    end
    @(negedge clk);
    wr_load       = 2'b01;
    bus.wd_finish = 1'b1;
    @(negedge clk);
    wr_load       = 2'b00;
    bus.wd_finish = 1'b0;
    wait_req(8, got, n);
    checks++;
    if (!got || n != 2 || obs_grant() !== exp_grant(0, 0, 28'h1000, 10'h40)) begin
      errors++; $display("FAIL load_with_finish: got %h n=%0d exp %h", obs_grant(), n, exp_grant(0, 0, 28'h1000, 10'h40));
    end
    pulse_fin(0);
    wfifo[10:0]  = 11'd0;
    wfifo[21:11] = 11'h100;
    wait_req(8, got, n);
    checks++;
    if (!got || obs_grant() !== exp_grant(0, 1, 28'h0000, 10'h40)) begin
      errors++; $display("FAIL load_idle_channel: got %h exp %h", obs_grant(), exp_grant(0, 1, 28'h0000, 10'h40));
    end
    pulse_fin(0);
  endtask

  task automatic test_reset_mid;
    bit got; int n;
    wfifo[21:11] = 11'd0;
    wfifo[10:0]  = 11'h100;
    wait_req(8, got, n);
    checks++;
    if (!got || obs_grant() !== exp_grant(0, 0, 28'h1040, 10'h40)) begin
      errors++; $display("FAIL rstmid_pre_grant: got %h exp %h", obs_grant(), exp_grant(0, 0, 28'h1040, 10'h40));
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.wd_req, bus.wd_addr, bus.wd_len} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got busy=%b addr=%h len=%h exp 0 0 0",
                         bus.busy, bus.wd_addr, bus.wd_len);
    end
    rst = 1'b0;
    wait_req(6, got, n);
    checks++;
    if (!got || n != 1 || obs_grant() !== exp_grant(0, 0, 28'h1000, 10'h40)) begin
      errors++; $display("FAIL rstmid_clamp_min: got %h n=%0d exp %h", obs_grant(), n, exp_grant(0, 0, 28'h1000, 10'h40));
    end
    pulse_fin(0);
    wfifo = '0;
  endtask

  initial begin
    rst           = 1'b1;
    init          = 1'b0;
    wr_load       = 2'b00;
    rd_load       = 2'b00;
    rd_valid      = 2'b11;
    bus.wd_finish = 1'b0;
    bus.rd_finish = 1'b0;
    wd_min = {28'h0000, 28'h1000};
    wd_max = {28'h0100, 28'h1100};
    rd_min = {28'h4000, 28'h2000};
    rd_max = {28'h4100, 28'h3000};
    wd_len = {10'h40, 10'h40};
    rd_len = {10'h10, 10'h20};
    wfifo  = {11'h100, 11'h100};
    rfifo  = {11'd0, 11'd0};

    test_reset;
    test_init;
    test_round_robin;
    test_write_wrap;
    test_rd_fifo;
    test_misconfig;
    test_load;
    test_reset_mid;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr3_mch_rw_arb.md
# ddr3_mch_rw_arb

Multi-channel DDR3 request arbiter and address generator, sitting in the ui_clk domain between per-channel CDC FIFOs and the AXI master. It generalises the single-channel read/write controller to CH_NUM write and CH_NUM read channels. Each channel has its own address window, burst length and frame-reload strobe. One burst at a time is granted under round-robin arbitration. Optional ping-pong banking is supported per channel.

## Interface
- CH_NUM, 2, number of write channels (and of read channels), 1..8
- ADDR_W, 28, address width; address and length share the same word unit
- LEN_W, 10, burst length width
- CNT_W, 11, FIFO fill-count width
- RFIFO_DEPTH, 1024, read-FIFO capacity in words
- BANK_OFFS, 28'h0800000, ping-pong bank offset (used only with the macro)
- CH_W = max(1, $clog2(CH_NUM)), derived
- clk  in  1  ui_clk; all logic is on this edge
- rst  in  1  asynchronous, active-high reset
- ddr3_init_done  in  1  no grant while low
- wr_load / rd_load  in  CH_NUM  one-cycle frame restart pulse per channel
- rd_valid  in  CH_NUM  read channel enable
- addr_wd_min, addr_wd_max, addr_rd_min, addr_rd_max  in  CH_NUM*ADDR_W  window per channel; channel i occupies bits [i*ADDR_W +: ADDR_W]
- wd_burst_len, rd_burst_len  in  CH_NUM*LEN_W  burst length per channel
- wfifo_rcount, rfifo_wcount  in  CH_NUM*CNT_W  FIFO fill counts
- wd_req / rd_req  out  1  one-cycle start pulse
- wd_addr, rd_addr  out  ADDR_W  burst address
- wd_len, rd_len  out  LEN_W  burst length
- wd_ch, rd_ch  out  CH_W  granted channel; selects the FIFO mux
- wd_finish / rd_finish  in  1  burst completion from the AXI master
- busy  out  1  high from grant until the pointer update

## Operation
- Requester k: writes k=0..CH_NUM-1; reads k=CH_NUM+i.
- Write i is eligible when all hold:
  - ddr3_init_done = 1
  - wd_burst_len_i != 0
  - addr_wd_min_i < addr_wd_max_i
  - wfifo_rcount_i >= wd_burst_len_i
- Read i is eligible when all hold:
  - ddr3_init_done = 1
  - rd_valid_i = 1
  - rd_burst_len_i != 0
  - addr_rd_min_i < addr_rd_max_i
  - rfifo_wcount_i + rd_burst_len_i <= RFIFO_DEPTH, computed at CNT_W+1 bits
- A channel with a misconfigured window or zero length is never eligible.
- FSM: IDLE -> GRANT -> WAIT -> UPDATE -> IDLE.
  - IDLE: if any requester is eligible, pick the first eligible one scanning from rr_ptr upward (wrapping modulo 2*CH_NUM), latch it, go to GRANT.
  - GRANT: assert wd_req or rd_req for exactly one cycle, with addr/len/ch valid; go to WAIT.
  - WAIT: hold addr/len/ch stable; leave on the matching finish (wd_finish for writes, rd_finish for reads). The other finish is ignored.
  - UPDATE: set next = ptr + len, computed at ADDR_W+1 bits. If next + len > max, then ptr := min (wrap); else ptr := next. Set rr_ptr := winner + 1 mod 2*CH_NUM.
- wr_load / rd_load:
  - For a channel not currently granted: ptr := min on the next edge.
  - For the granted channel: the load is remembered and applied in UPDATE instead of the increment. The in-flight burst is never aborted.
- Every pointer resets to 0. The first burst after reset, or after a load, uses min once ptr < min is detected: ptr is clamped to min in IDLE.

## Timing
- Eligibility seen at cycle N -> GRANT at N+1 -> req pulse visible at N+1.
- Minimum turnaround: finish at cycle M -> UPDATE at M+1 -> IDLE at M+2 -> next req at M+3.
- busy goes high in GRANT and low after UPDATE.
- Reset values: wd_req = rd_req = 0, all addr/len/ch = 0, busy = 0, FSM = IDLE, rr_ptr = 0, all bank bits = 0.
- rst asserted mid-burst returns the FSM to IDLE immediately; the AXI master is reset in parallel.
- Load and finish in the same cycle on the granted channel: the load wins, ptr := min.

## Configuration
- DDR3_PINGPONG_EN defined:
  - Each channel keeps wbank_i and rbank_i.
  - A write wrap toggles wbank_i.
  - A read wrap sets rbank_i := ~wbank_i, so reads never touch the bank being written.
  - Output address = ptr + (bank ? BANK_OFFS : 0).
  - Loads do not change bank bits.
- DDR3_PINGPONG_EN undefined: no bank state; output address = ptr.

## Test plan
- CH_NUM=2, init_done=0, all FIFOs ready -> no req ever. Raise init_done -> wd_req ch0 at addr_wd_min0 one cycle later.
- All four requesters eligible continuously -> grant order w0, w1, r0, r1, w0; each grant follows its finish by 3 cycles.
- Write ch1: min=0, max=0x100, len=0x40 -> addresses 0x00, 0x40, 0x80, 0xC0, then 0x00.
- rfifo_wcount0=1000, rd_len=32 -> read 0 not eligible; at 992 -> eligible.
- wr_load0 during WAIT of ch0 at addr 0x80 -> next ch0 burst at min, and the current burst is not truncated.
- DDR3_PINGPONG_EN, BANK_OFFS=0x800000 -> after the first write wrap, writes use +0x800000 and reads use bank 0.
